// File: rtl/row_req_encoder_8x3.sv
// row_req_encoder_8x3
//   Collects per-row access/refresh requests (one line per word line) into a
//   sticky pending vector and offers them one at a time as an encoded row
//   address to the 3x8 word-line decoder. Rows are served round-robin. Each
//   offer uses a valid/ready handshake. Back-to-back offers sustain one grant
//   per clock.
//
// Ports
//   clk         in   1       clock, all state on rising edge
//   rst         in   1       asynchronous active-high reset
//   en          in   1       block enable (0: ignore new req, start no new offer)
//   req         in   N_ROWS  request lines, bit i = row i
//   addr        out  ADDR_W  registered encoded row address on offer
//   addr_valid  out  1       registered, addr is a valid offer
//   addr_ready  in   1       consumer accepts addr
//   pending     out  N_ROWS  registered sticky request vector
//   busy        out  1       any row pending or an offer outstanding
//
// N_ROWS must equal 2**ADDR_W. The scan arithmetic relies on ADDR_W-bit
// wraparound to implement "mod N_ROWS".
module row_req_encoder_8x3 #(
  parameter int N_ROWS = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [N_ROWS-1:0] req,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [N_ROWS-1:0] pending,
  output logic              busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [0:0]        state_reg, state_next;
  logic [N_ROWS-1:0] pending_reg, pending_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              addr_valid_reg, addr_valid_next;

  logic [N_ROWS-1:0] addr_onehot;
  logic [N_ROWS-1:0] clr;
  logic [N_ROWS-1:0] rem;
  logic [ADDR_W-1:0] addr_inc;
  logic              handshake;

  // First set bit of v when scanning p, p+1, ... with wraparound.
  // Returns p when v is empty (callers never use that result).
  function automatic logic [ADDR_W-1:0] sel_fn(input logic [N_ROWS-1:0] v,
                                              input logic [ADDR_W-1:0] p);
    logic [ADDR_W-1:0] idx;
    logic              found;
    sel_fn = p;
    found  = 1'b0;
    for (int k = 0; k < N_ROWS; k++) begin
      idx = p + ADDR_W'(k);
      if (!found && v[idx]) begin
        sel_fn = idx;
        found  = 1'b1;
      end
    end
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N_ROWS; gi++) begin : g_onehot
      assign addr_onehot[gi] = (addr_reg == ADDR_W'(gi));
    end
  endgenerate

  assign handshake = addr_valid_reg & addr_ready;
  assign clr       = handshake ? addr_onehot : '0;
  assign addr_inc  = addr_reg + ADDR_W'(1);
  // Remaining rows after the current grant. A request arriving on this same
  // edge is not in rem; the next cycle sees it through pending_reg.
  assign rem       = pending_reg & ~addr_onehot;

  always_comb begin
    // Set wins over clear, so a re-request of the granted row stays pending.
    pending_next    = (pending_reg & ~clr) | (req & {N_ROWS{en}});
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    addr_next       = addr_reg;
    addr_valid_next = addr_valid_reg;

    case (state_reg)
      IDLE: begin
        if (en && (|pending_reg)) begin
          addr_next       = sel_fn(pending_reg, ptr_reg);
          addr_valid_next = 1'b1;
          state_next      = OFFER;
        end
      end
      OFFER: begin
        // Offer is held (even if en falls) until the consumer takes it.
        if (addr_ready) begin
          ptr_next = addr_inc;
          if (en && (|rem)) begin
            addr_next = sel_fn(rem, addr_inc);
          end else begin
            addr_valid_next = 1'b0;
            state_next      = IDLE;
          end
        end
      end
      default: begin
        addr_valid_next = 1'b0;
        state_next      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      ptr_reg        <= '0;
      addr_reg       <= '0;
      addr_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      ptr_reg        <= ptr_next;
      addr_reg       <= addr_next;
      addr_valid_reg <= addr_valid_next;
    end
  end

  assign addr       = addr_reg;
  assign addr_valid = addr_valid_reg;
  assign pending    = pending_reg;
  assign busy       = (|pending_reg) | addr_valid_reg;

endmodule
